// File: rtl/rkm_pkg.sv
// Shared definitions for the round-key mixer: FSM states, default geometry
// and the AES round counts that size the round-key store.
package rkm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROC = 2'd1,
      DONE = 2'd2
   } rkm_state_e;

   localparam int DEFAULT_BLOCK_W = 128;
   localparam int DEFAULT_LANE_W  = 32;
   localparam int DEFAULT_NUM_RK  = 11;

   localparam int AES128_ROUNDS = 10;
   localparam int AES192_ROUNDS = 12;
   localparam int AES256_ROUNDS = 14;

   // Index width that still works for a single-entry store.
   function automatic int rkm_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/round_key_mixer_if.sv
// Handshake and key-write bundle between the round controller (master)
// and the round-key mixer (slave).
interface round_key_mixer_if
   import rkm_pkg::*;
#(
   parameter int BLOCK_W = DEFAULT_BLOCK_W,
   parameter int NUM_RK  = DEFAULT_NUM_RK
);
   localparam int IW = rkm_idx_w(NUM_RK);

   logic               key_we;
   logic [IW-1:0]      key_idx;
   logic [BLOCK_W-1:0] key_wdata;
   logic               key_ready;
   logic               in_valid;
   logic               in_ready;
   logic [BLOCK_W-1:0] in_data;
   logic [IW-1:0]      in_idx;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] out_data;
   logic               out_err;
   logic               busy;

   modport master (
      output key_we, key_idx, key_wdata, in_valid, in_data, in_idx, out_ready,
      input  key_ready, in_ready, out_valid, out_data, out_err, busy
   );

   modport slave (
      input  key_we, key_idx, key_wdata, in_valid, in_data, in_idx, out_ready,
      output key_ready, in_ready, out_valid, out_data, out_err, busy
   );

endinterface

// File: rtl/rkm_key_store.sv
// Round-key register file: one write port, one combinational read port.
// Reading an index with no backing entry returns an all-zero key.
module rkm_key_store
   import rkm_pkg::*;
#(
   parameter int BLOCK_W = DEFAULT_BLOCK_W,
   parameter int NUM_RK  = DEFAULT_NUM_RK,
   parameter int IW      = rkm_idx_w(NUM_RK)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_we,
   input  logic [IW-1:0]      i_widx,
   input  logic [BLOCK_W-1:0] i_wdata,
   input  logic [IW-1:0]      i_ridx,
   output logic [BLOCK_W-1:0] o_rdata
);

   logic [BLOCK_W-1:0] r_keys [NUM_RK];

   // Writes to indexes beyond the store match no entry and are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_RK; i++) begin
            r_keys[i] <= '0;
         end
      end else if (i_we) begin
         for (int i = 0; i < NUM_RK; i++) begin
            if (i_widx == IW'(i)) begin
               r_keys[i] <= i_wdata;
            end
         end
      end
   end

   always_comb begin
      o_rdata = '0;
      for (int i = 0; i < NUM_RK; i++) begin
         if (i_ridx == IW'(i)) begin
            o_rdata = r_keys[i];
         end
      end
   end

endmodule

// File: rtl/round_key_mixer.sv
// Lane-serial AddRoundKey: XORs a latched state block with a stored round
// key LANE_W bits per cycle and hands the result out on valid/ready.
module round_key_mixer
   import rkm_pkg::*;
#(
   parameter int BLOCK_W = DEFAULT_BLOCK_W,
   parameter int LANE_W  = DEFAULT_LANE_W,
   parameter int NUM_RK  = DEFAULT_NUM_RK
) (
   input logic              clk,
   input logic              rst,
   round_key_mixer_if.slave bus
);

   localparam int BEATS = BLOCK_W / LANE_W;
   localparam int IW    = rkm_idx_w(NUM_RK);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [IW:0]   NUM_RK_X  = (IW + 1)'(NUM_RK);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   if (BLOCK_W % LANE_W != 0) begin : g_laneCheck
      $error("round_key_mixer: LANE_W must divide BLOCK_W");
   end

   rkm_state_e         r_state;
   rkm_state_e         w_nextState;
   logic [BLOCK_W-1:0] r_data;
   logic [IW-1:0]      r_idx;
   logic [BW-1:0]      r_beat;
   logic               r_err;
   logic               w_accept;
   logic               w_keyWe;
   logic [BLOCK_W-1:0] w_key;

   // Keys are only writable in IDLE, so an in-flight block never sees a change.
   assign w_accept = (r_state == IDLE) && bus.in_valid;
   assign w_keyWe  = (r_state == IDLE) && bus.key_we;

   rkm_key_store #(
      .BLOCK_W (BLOCK_W),
      .NUM_RK  (NUM_RK),
      .IW      (IW)
   ) u_keyStore (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_keyWe),
      .i_widx  (bus.key_idx),
      .i_wdata (bus.key_wdata),
      .i_ridx  (r_idx),
      .o_rdata (w_key)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState   = r_state;
      bus.in_ready  = 1'b0;
      bus.key_ready = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b1;
      case (r_state)
         IDLE: begin
            bus.in_ready  = 1'b1;
            bus.key_ready = 1'b1;
            bus.busy      = 1'b0;
            if (bus.in_valid) begin
               w_nextState = PROC;
            end
         end
         PROC: begin
            if (r_beat == LAST_BEAT) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // The key read is registered-index only, so a key written in the accept
   // cycle is already visible when the first lane is mixed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
         r_idx  <= '0;
         r_beat <= '0;
         r_err  <= 1'b0;
      end else if (w_accept) begin
         r_data <= bus.in_data;
         r_idx  <= bus.in_idx;
         r_err  <= ({1'b0, bus.in_idx} >= NUM_RK_X);
         r_beat <= '0;
      end else if (r_state == PROC) begin
         for (int b = 0; b < BEATS; b++) begin
            if (r_beat == BW'(b)) begin
               r_data[b*LANE_W +: LANE_W] <= r_data[b*LANE_W +: LANE_W] ^ w_key[b*LANE_W +: LANE_W];
            end
         end
         r_beat <= r_beat + BW'(1);
      end
   end

   assign bus.out_data = r_data;
   assign bus.out_err  = r_err;

endmodule

// File: doc/round_key_mixer.md
# round_key_mixer

Parametrised, lane-serial AddRoundKey engine with on-chip round-key storage. It holds up to NUM_RK round keys loaded through a write port and accepts one state block per transaction with a round-key index. It XORs the block with the selected key LANE_W bits per cycle and returns the result through a valid/ready handshake. It sits between the round controller and the SubBytes/ShiftRows/MixColumns datapath, and replaces the single-cycle combinational AddRoundKey where area matters.

## Interface
Parameters:
- BLOCK_W, 128, state/key width in bits
- LANE_W, 32, bits processed per cycle; must divide BLOCK_W
- NUM_RK, 11, number of stored round keys (11/13/15 for AES-128/192/256)
- Derived: BEATS = BLOCK_W/LANE_W; IW = $clog2(NUM_RK)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- key_we  in  1  round-key write strobe
- key_idx  in  IW  round-key write index
- key_wdata  in  BLOCK_W  round-key value
- key_ready  out  1  key write accepted this cycle (high only in IDLE)
- in_valid  in  1  block present
- in_ready  out  1  engine can accept a block
- in_data  in  BLOCK_W  state block
- in_idx  in  IW  round-key index to apply
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_data  out  BLOCK_W  in_data XOR key[in_idx]
- out_err  out  1  in_idx was ≥ NUM_RK; out_data = in_data unmodified
- busy  out  1  state != IDLE

## Operation
- FSM has 3 states: IDLE, PROC, DONE.
- IDLE: in_ready=1, key_ready=1.
  - If in_valid, latch in_data, in_idx and the out-of-range flag, clear beat to 0, go to PROC.
  - If key_we, write key_wdata into key[key_idx] at the same edge.
  - key_we with key_idx ≥ NUM_RK is dropped.
- PROC: each cycle, lane[beat] = data[beat*LANE_W +: LANE_W] ^ key[idx][same slice]. Lane 0 is bits [LANE_W-1:0].
  - beat increments each cycle.
  - On beat == BEATS-1, go to DONE.
  - If the index is out of range, the key is treated as zero.
- DONE: out_valid=1; out_data and out_err are stable. On out_ready, return to IDLE.
- key_we outside IDLE is ignored (key_ready=0). Keys never change under an in-flight block.
- Simultaneous key_we and accept in IDLE: the block uses the newly written key when the indexes match.
- Reset clears all key entries to 0, the data register, beat, and out_err. State goes to IDLE.
- Reset mid-transaction aborts the block; no output is produced.

## Timing
- Reset values: in_ready=1, key_ready=1, out_valid=0, out_data=0, out_err=0, busy=0.
- Accept at edge T. out_valid rises after edge T+BEATS (4 cycles for the defaults). With BEATS=1, that is the cycle after acceptance.
- Minimum block period is BEATS+2 cycles: accept, BEATS PROC cycles, then 1 DONE cycle with out_ready already high.
- out_valid holds and out_data is stable until out_ready; back-pressure of any length is legal.
- in_ready is combinational from state only and does not depend on in_valid.
- out_valid is combinational from state only.

## Structure
- Shared package rkm_pkg holds:
  - the state enum (IDLE, PROC, DONE);
  - the default BLOCK_W/LANE_W/NUM_RK constants;
  - the AES-128/192/256 round counts.
- Sub-module rkm_key_store: an NUM_RK × BLOCK_W register file with async reset, a write port, and a combinational read by index with the out-of-range-is-zero rule.
- Top level holds the FSM, beat counter, data register and lane XOR.
- Elaboration-time assertion: BLOCK_W % LANE_W == 0.

## Test plan
- FIPS-197 round 0:
  - key[0]=000102030405060708090a0b0c0d0e0f, in_data=00112233445566778899aabbccddeeff, idx 0.
  - Required: out_data=00102030405060708090a0b0c0d0e0f0, out_err=0, out_valid exactly 4 cycles after acceptance.
- Back-pressure: hold out_ready=0 for 10 cycles.
  - out_data is stable throughout.
  - in_ready=0 and key_ready=0 throughout.
  - The second block is accepted only after the out handshake.
- Same-cycle write and accept in IDLE:
  - key[3]=FF…FF written while a block of 0 with idx 3 is accepted.
  - Required: out_data=FF…FF.
  - A key_we to idx 3 during PROC is ignored; the following block still sees FF…FF.
- Out-of-range index: in_idx=12 with NUM_RK=11.
  - Required: out_data=in_data, out_err=1.
  - A key_we to idx 12 has no effect on entries 0–10.
- Reset mid-PROC:
  - Assert rst at beat 2.
  - Required: out_valid never rises, all keys read back as 0, in_ready=1 immediately after reset.
- Parameter sweep:
  - LANE_W=128: latency 1.
  - LANE_W=8: latency 16.
  - Random blocks and keys in each configuration, checked against a combinational XOR model.
